ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
Parametrised, elastic EX/MEM pipeline register, the successor to the fixed free-running EX/MEM latch. It carries branch target, ALU result, store data, zero/branch flags and a generic control bundle. It adds valid/ready handshaking, an optional 2-entry skid buffer for back-pressure, synchronous flush on branch mispredict, and stall instrumentation. It sits between the EX stage (upstream) and the MEM stage (downstream); all state updates on the rising edge of Clk.

Parameters:
DATA_W, 32, width of each data field (AddResult, ALUResult, ReadData2)
CTRL_W, 8, width of the pass-through control bundle (MemRead, MemWrite, RegWrite, ...)
SKID, 1, 1 = 2-entry skid buffer with registered In_Ready; 0 = single entry with combinational In_Ready

Ports:
Clk  in  1  clock, rising edge active
Rst_n  in  1  asynchronous reset, active low
In_Valid  in  1  EX presents a valid instruction
In_Ready  out  1  stage can accept this cycle
In_AddResult  in  DATA_W  branch target
In_ALUResult  in  DATA_W  ALU result / memory address
In_ReadData2  in  DATA_W  store data
In_Zero  in  1  ALU zero flag
In_BranchSend  in  1  instruction is a branch
In_Ctrl  in  CTRL_W  control bundle
Flush  in  1  synchronous kill of all held entries
Out_Valid  out  1  Out_* fields hold a valid instruction
Out_Ready  in  1  MEM accepts this cycle
Out_AddResult, Out_ALUResult, Out_ReadData2  out  DATA_W each  registered copies of the inputs
Out_Zero, Out_BranchSend  out  1 each  registered flags
Out_Ctrl  out  CTRL_W  registered control bundle
Out_PCSrc  out  1  Out_Valid & Out_Zero & Out_BranchSend (combinational from registers)
Occupancy  out  2  number of held entries (0..2; max 1 when SKID=0)
StallCount  out  16  saturating count of back-pressured cycles

Behaviour:
- Reset (Rst_n low, asynchronous): all Out_* zero, Out_Valid 0, Occupancy 0, StallCount 0, skid entry invalid. In_Ready = 1 while in reset and after release.
- Accept = In_Valid & In_Ready. Deliver = Out_Valid & Out_Ready. Latency from accept to Out_Valid is 1 cycle. Data never changes while Out_Valid & !Out_Ready.
- SKID=1 state machine (state = Occupancy):
  - EMPTY: accept -> ONE; main register loads the input.
  - ONE: accept & !deliver -> TWO; skid register loads the input.
  - ONE: accept & deliver -> ONE; main loads the input.
  - ONE: deliver only -> EMPTY.
  - ONE: neither -> hold.
  - TWO: deliver -> ONE; main loads skid. Otherwise hold.
  - In_Ready is a register: 1 unless the next state is TWO. No combinational path from Out_Ready to In_Ready.
  - Accept in TWO is impossible. The bench flags it as an error.
- SKID=0: single entry. In_Ready = !Out_Valid | Out_Ready (combinational). Accept loads main. Occupancy is 0 or 1.
- Order is preserved: an entry in main is always older than the entry in skid.
- Flush (synchronous, highest priority):
  - Next state is EMPTY, Out_Valid 0, skid invalid, In_Ready 1.
  - A same-cycle input is discarded, not captured.
  - Data registers hold their values (don't care once invalid).
  - Out_PCSrc goes 0 the next cycle.
- Flush while Rst_n is low: reset dominates.
- StallCount increments by 1 every cycle with Out_Valid & !Out_Ready and saturates at 16'hFFFF. It is cleared only by reset, not by Flush.
- Out_PCSrc is masked by Out_Valid, so a stale branch never redirects the PC.

Test Plan:
- Reset: drive Rst_n=0 mid-cycle with Occupancy=2 -> immediately Out_Valid=0, Occupancy=0, StallCount=0, all Out_* 0, In_Ready=1.
- Streaming: Out_Ready=1, accept ALUResult 1,2,3,4 on consecutive cycles -> Out_ALUResult 1,2,3,4 one cycle later each, Occupancy stays 1, StallCount 0.
- Back-pressure (SKID=1): Out_Ready=0 and accept A=0x10, B=0x20 -> Occupancy=2, In_Ready=0, Out=0x10 held. Release Out_Ready -> 0x10 then 0x20 delivered in order, no loss or duplication. StallCount equals the held cycles.
- Flush: Occupancy=2, then Flush=1 with In_Valid=1 carrying 0x99 -> next cycle Out_Valid=0, Occupancy=0. 0x99 never appears. StallCount unchanged.
- Branch: accept Zero=1, BranchSend=1, AddResult=0x400 -> Out_PCSrc=1 and Out_AddResult=0x400 next cycle. After delivery with no new input, Out_PCSrc=0.
- Saturation and SKID=0: hold Out_Ready=0 for 70000 cycles -> StallCount=0xFFFF. With SKID=0, an accept and a deliver in the same cycle keep Occupancy=1, and In_Ready tracks Out_Ready combinationally.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// Elastic EX/MEM pipeline register: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush on mispredict and a saturating stall counter.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_AddResult,
  input  logic [DATA_W-1:0] In_ALUResult,
  input  logic [DATA_W-1:0] In_ReadData2,
  input  logic              In_Zero,
  input  logic              In_BranchSend,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_AddResult,
  output logic [DATA_W-1:0] Out_ALUResult,
  output logic [DATA_W-1:0] Out_ReadData2,
  output logic              Out_Zero,
  output logic              Out_BranchSend,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic              Out_PCSrc,
  output logic [1:0]        Occupancy,
  output logic [15:0]       StallCount
);

  typedef struct packed {
    logic [DATA_W-1:0] add_result;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data2;
    logic              zero;
    logic              branch;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t     in_e, main_q;
  logic [1:0] occ;
  logic       accept, deliver;

  assign in_e    = '{In_AddResult, In_ALUResult, In_ReadData2, In_Zero, In_BranchSend, In_Ctrl};
  assign accept  = In_Valid & In_Ready;
  assign deliver = Out_Valid & Out_Ready;

  assign Occupancy      = occ;
  assign Out_Valid      = (occ != 2'd0);
  assign Out_AddResult  = main_q.add_result;
  assign Out_ALUResult  = main_q.alu_result;
  assign Out_ReadData2  = main_q.read_data2;
  assign Out_Zero       = main_q.zero;
  assign Out_BranchSend = main_q.branch;
  assign Out_Ctrl       = main_q.ctrl;
  // Masked by valid so a stale branch left in main never redirects the PC.
  assign Out_PCSrc      = Out_Valid & main_q.zero & main_q.branch;

  generate
    if (SKID != 0) begin : g_skid
      entry_t     skid_q;
      logic       rdy_q;
      logic [1:0] occ_nxt;

      assign In_Ready = rdy_q;

      always_comb begin
        occ_nxt = occ;
        if (Flush) occ_nxt = 2'd0;
        else begin
          case (occ)
            2'd0:    if (accept) occ_nxt = 2'd1;
            2'd1:    if (accept && !deliver) occ_nxt = 2'd2;
                     else if (!accept && deliver) occ_nxt = 2'd0;
            default: if (deliver) occ_nxt = 2'd1;
          endcase
        end
      end

      // Ready is registered from the next state, so Out_Ready never reaches In_Ready.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          occ    <= 2'd0;
          rdy_q  <= 1'b1;
          main_q <= '0;
          skid_q <= '0;
        end else begin
          occ   <= occ_nxt;
          rdy_q <= (occ_nxt != 2'd2);
          if (!Flush) begin
            case (occ)
              2'd0:    if (accept) main_q <= in_e;
              2'd1:    if (accept && deliver) main_q <= in_e;
                       else if (accept) skid_q <= in_e;
              default: if (deliver) main_q <= skid_q;
            endcase
          end
        end
      end
    end else begin : g_single
      assign In_Ready = !Out_Valid | Out_Ready;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          occ    <= 2'd0;
          main_q <= '0;
        end else if (Flush) begin
          occ <= 2'd0;
        end else if (accept) begin
          occ    <= 2'd1;
          main_q <= in_e;
        end else if (deliver) begin
          occ <= 2'd0;
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) StallCount <= 16'd0;
    else if (Out_Valid && !Out_Ready && StallCount != 16'hFFFF)
      StallCount <= StallCount + 16'd1;
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: a SKID=0 and a SKID=1 instance share stimulus;
// each is modelled as a FIFO of accepted-but-undelivered instructions.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [31:0] add_result;
    logic [31:0] alu_result;
    logic [31:0] read_data2;
    logic        zero;
    logic        branch;
    logic [7:0]  ctrl;
  } entry_t;

  logic   clk = 0, rst_n = 1, in_valid = 0, out_ready = 0, flush = 0, mon_en = 0;
  entry_t in_e = '0;

  logic        i_rdy [2], o_vld [2], o_zero [2], o_br [2], o_pc [2];
  logic [31:0] o_add [2], o_alu [2], o_rd2 [2];
  logic [7:0]  o_ctrl [2];
  logic [1:0]  o_occ [2];
  logic [15:0] o_stall [2];

  entry_t      sb [2][$];
  logic [15:0] stall_m [2];
  logic        p_acc [2];
  logic        p_flush = 0;
  entry_t      p_e = '0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_s0 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(i_rdy[0]),
    .In_AddResult(in_e.add_result), .In_ALUResult(in_e.alu_result), .In_ReadData2(in_e.read_data2),
    .In_Zero(in_e.zero), .In_BranchSend(in_e.branch), .In_Ctrl(in_e.ctrl), .Flush(flush),
    .Out_Valid(o_vld[0]), .Out_Ready(out_ready), .Out_AddResult(o_add[0]), .Out_ALUResult(o_alu[0]),
    .Out_ReadData2(o_rd2[0]), .Out_Zero(o_zero[0]), .Out_BranchSend(o_br[0]), .Out_Ctrl(o_ctrl[0]),
    .Out_PCSrc(o_pc[0]), .Occupancy(o_occ[0]), .StallCount(o_stall[0]));

  ex_mem_pipe_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_s1 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(i_rdy[1]),
    .In_AddResult(in_e.add_result), .In_ALUResult(in_e.alu_result), .In_ReadData2(in_e.read_data2),
    .In_Zero(in_e.zero), .In_BranchSend(in_e.branch), .In_Ctrl(in_e.ctrl), .Flush(flush),
    .Out_Valid(o_vld[1]), .Out_Ready(out_ready), .Out_AddResult(o_add[1]), .Out_ALUResult(o_alu[1]),
    .Out_ReadData2(o_rd2[1]), .Out_Zero(o_zero[1]), .Out_BranchSend(o_br[1]), .Out_Ctrl(o_ctrl[1]),
    .Out_PCSrc(o_pc[1]), .Occupancy(o_occ[1]), .StallCount(o_stall[1]));

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s skid%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic entry_t rnd();
    entry_t e;
    e.add_result = $urandom; e.alu_result = $urandom; e.read_data2 = $urandom;
    e.zero = 1'($urandom_range(0, 1)); e.branch = 1'($urandom_range(0, 1));
    e.ctrl = 8'($urandom);
    return e;
  endfunction

  function automatic entry_t with_alu(input logic [31:0] alu);
    entry_t e = rnd();
    e.alu_result = alu;
    return e;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      sb[d].delete(); stall_m[d] = 16'd0; p_acc[d] = 1'b0;
    end
    p_flush = 1'b0;
  endtask

  // One clock of stimulus: commit last cycle's edge into the model, drive new inputs,
  // check the predicted In_Ready and record what the coming edge will capture.
  task automatic cycle(input logic v, input entry_t e, input logic ordy, input logic fl);
    logic exp_rdy;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      if (p_flush) sb[d].delete();
      else if (p_acc[d]) sb[d].push_back(p_e);
    end
    in_valid = v; in_e = e; out_ready = ordy; flush = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy = (d == 1) ? (sb[d].size() != 2) : (sb[d].size() == 0 || ordy);
      chk("in_ready", d, i_rdy[d], exp_rdy);
      p_acc[d] = v && exp_rdy && !fl;
    end
    p_flush = fl; p_e = e;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rnd(), ordy, 1'b0);
  endtask

  task automatic chk_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, o_vld[d], 0);   chk("rst_occ", d, o_occ[d], 0);
      chk("rst_stall", d, o_stall[d], 0); chk("rst_ready", d, i_rdy[d], 1);
      chk("rst_add", d, o_add[d], 0);     chk("rst_alu", d, o_alu[d], 0);
      chk("rst_rd2", d, o_rd2[d], 0);     chk("rst_ctrl", d, o_ctrl[d], 0);
      chk("rst_zero", d, o_zero[d], 0);   chk("rst_br", d, o_br[d], 0);
      chk("rst_pcsrc", d, o_pc[d], 0);
    end
  endtask

  always @(negedge clk) begin
    entry_t f;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("occupancy", d, o_occ[d], sb[d].size());
        chk("out_valid", d, o_vld[d], sb[d].size() != 0);
        chk("stall_count", d, o_stall[d], stall_m[d]);
        if (sb[d].size() != 0) begin
          f = sb[d][0];
          chk("add_result", d, o_add[d], f.add_result);
          chk("alu_result", d, o_alu[d], f.alu_result);
          chk("read_data2", d, o_rd2[d], f.read_data2);
          chk("ctrl", d, o_ctrl[d], f.ctrl);
          chk("zero", d, o_zero[d], f.zero);
          chk("branch", d, o_br[d], f.branch);
          chk("pcsrc", d, o_pc[d], f.zero & f.branch);
          if (out_ready) void'(sb[d].pop_front());
          else if (stall_m[d] != 16'hFFFF) stall_m[d] = stall_m[d] + 16'd1;
        end else begin
          chk("pcsrc_idle", d, o_pc[d], 0);
        end
      end
    end
  end

  initial begin
    entry_t e;
    clear_model();
    #1 rst_n = 0;
    #2 chk_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    chk_reset();
    mon_en = 1;

    // streaming at full rate
    for (int i = 1; i <= 4; i++) cycle(1'b1, with_alu(32'(i)), 1'b1, 1'b0);
    idle(1'b1, 3);

    // back-pressure: two entries held, then drained in order
    cycle(1'b1, with_alu(32'h10), 1'b0, 1'b0);
    cycle(1'b1, with_alu(32'h20), 1'b0, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, 4);

    // flush with full skid and a same-cycle input that must be discarded
    cycle(1'b1, with_alu(32'h30), 1'b0, 1'b0);
    cycle(1'b1, with_alu(32'h40), 1'b0, 1'b0);
    cycle(1'b1, with_alu(32'h99), 1'b0, 1'b1);
    idle(1'b1, 3);

    // taken branch
    e = rnd(); e.zero = 1; e.branch = 1; e.add_result = 32'h400;
    cycle(1'b1, e, 1'b1, 1'b0);
    idle(1'b1, 3);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
    idle(1'b1, 4);

    // stall counter saturation
    cycle(1'b1, rnd(), 1'b0, 1'b0);
    idle(1'b0, 70000);
    for (int d = 0; d < 2; d++) chk("stall_saturated", d, o_stall[d], 16'hFFFF);

    // asynchronous reset mid-cycle with the skid instance full
    cycle(1'b1, rnd(), 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("occ_before_reset", 1, o_occ[1], 2);
    #1 mon_en = 0; rst_n = 0;
    #1 chk_reset();
    clear_model();
    #20 rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
